udp_rx_drain_ctrl: RTL and testbench
====================================

// Module: udp_rx_drain_ctrl
// PURPOSE
//  Sequencer for the read port of the UDP receive RAM (8x2048). When the UDP receiver reports a good datagram, it walks the payload addresses.
//  It captures a 4-byte application header (line index + flags) and streams the remaining payload bytes to the video packer over a valid/ready interface.
//  Sits between the UDP receiver (udp_rec_ram_read_addr/rdata, udp_rec_data_valid/length) and the eth-to-HDMI path.
// PARAMETERS
//  ADDR_W    11    RAM read address width
//  HDR_BYTES 4     application header bytes at payload start (fixed 4: line[15:0], flags[15:0], big-endian)
//  UDP_HDR   8     UDP header bytes included in udp_rec_data_length
//  MAX_PAY   2048  largest payload (bytes) the RAM holds
// PORTS
//  clk             in  1      system clock
//  rst             in  1      synchronous, active-high reset
//  rec_valid       in  1      one-cycle pulse: datagram in RAM is good (udp_rec_data_valid)
//  rec_length      in  16     UDP length incl. 8-byte UDP header (udp_rec_data_length)
//  ram_rd_addr     out ADDR_W RAM read address; data returns exactly 1 cycle later
//  ram_rd_data     in  8      RAM read data
//  m_data          out 8      payload byte
//  m_valid         out 1      m_data valid; held with m_data stable until m_ready
//  m_ready         in  1      downstream accepts when m_valid&&m_ready
//  m_sof / m_eof   out 1      first / last payload byte of the datagram (qualified by m_valid)
//  hdr_line        out 16     captured line index; hdr_flags out 16 captured flags
//  hdr_valid       out 1      one-cycle pulse when both header fields are updated
//  busy            out 1      high from accept of rec_valid until DONE exits
//  len_err         out 1      one-cycle pulse: rejected length
//  drop_cnt        out 16     saturating count of rejected or ignored datagrams
// BEHAVIOUR
//  - Reset values: ram_rd_addr=0, m_valid=0, m_sof=m_eof=0, m_data=0, hdr_*=0, hdr_valid=0, busy=0, len_err=0, drop_cnt=0.
//    The internal FIFO and in-flight flag are cleared. State=IDLE.
//  - Reset mid-operation discards everything; no partial m_eof is emitted.
//  - pay = rec_length-UDP_HDR, computed in 16 bits and latched in IDLE on rec_valid.
//  - Reject condition: rec_length<UDP_HDR+HDR_BYTES, or pay>MAX_PAY.
//    On reject: len_err pulses next cycle, drop_cnt+1, stay IDLE.
//  - States: IDLE -> HDR -> PAY -> DONE -> IDLE.
//    IDLE: accept rec_valid; ram_rd_addr=0 issued in the cycle after the pulse.
//    HDR: issue addr 0..3 back-to-back (no backpressure); capture bytes on return.
//      Byte0=line[15:8], byte1=line[7:0], byte2=flags[15:8], byte3=flags[7:0].
//      hdr_valid pulses the cycle after byte3 returns.
//      Go PAY if pay>HDR_BYTES, else go DONE (no stream beats).
//    PAY: issue addr 4..pay-1 into a 2-entry output FIFO using credits.
//      A read is issued only if (fifo_count + inflight - pop) < 2, with pop = m_valid&&m_ready.
//      This gives full throughput of 1 byte/cycle when m_ready is held high and never overflows.
//      m_sof is tagged on addr 4; m_eof is tagged on addr pay-1.
//      Leave PAY when the final read is issued.
//    DONE: wait until the FIFO is empty and nothing is in flight, then deassert busy and go IDLE.
//  - rec_valid while busy: ignored, drop_cnt+1; the latched length is unchanged.
//    rec_valid coinciding with the DONE exit cycle also counts as busy.
//  - drop_cnt saturates at 16'hFFFF. A reject and an ignore never coincide (one pulse per cycle).
//  - m_data/m_sof/m_eof come from the FIFO head; m_valid = FIFO non-empty.
//  - Address arithmetic uses ADDR_W bits; pay=MAX_PAY reads addr 2047 last, with no wrap.
// STRUCTURE
//  - Shared package eth_rx_pkg: state encoding localparams (IDLE/HDR/PAY/DONE) and the UDP_HDR / HDR_BYTES / MAX_PAY constants.
//  - One sub-module: udp_drain_fifo2, a 2-entry {eof,sof,data[7:0]} FIFO with count output and sync rst.
//  - Sequencer, credit logic and header capture stay in this top.
// TESTING
//  1. rec_length=16 (pay 8), RAM[0..7]=00 05 80 01 A0 A1 A2 A3, m_ready=1:
//     hdr_line=0x0005 and hdr_flags=0x8001 with one hdr_valid.
//     Beats A0..A3 on 4 consecutive cycles, sof on A0, eof on A3; busy falls after A3.
//  2. Same packet with m_ready toggling 1,0,0,1,...: no byte lost or duplicated.
//     m_data is stable while stalled, and FIFO count never exceeds 2.
//  3. rec_length=12 (pay 4): header captured, hdr_valid pulses, zero m_valid beats, back to IDLE.
//  4. rec_length=10 -> len_err pulse, drop_cnt=1, no RAM reads.
//     rec_length=2064 (pay 2056) -> len_err, drop_cnt=2.
//  5. Second rec_valid 3 cycles into a 1000-byte drain -> drop_cnt+1.
//     The first drain completes all 996 beats unchanged.
//  6. Assert rst mid-PAY -> all outputs at reset values next cycle.
//     A following rec_length=16 packet drains correctly; drop_cnt preset to 0xFFFF stays 0xFFFF after another reject.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared constants and types for the UDP receive drain path.
// Used by the drain sequencer and its output FIFO.
package eth_rx_pkg;

    localparam int ADDR_W    = 11;
    localparam int UDP_HDR   = 8;
    localparam int HDR_BYTES = 4;
    localparam int MAX_PAY   = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        DONE = 2'd3
    } drain_state_e;

endpackage

// File: rtl/udp_drain_fifo2.sv
// Two-entry {eof,sof,data} FIFO between the RAM read pipe and the stream port.
// Upstream credit logic guarantees push never lands on a full FIFO.
module udp_drain_fifo2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [9:0] din,
    input  logic       pop,
    output logic [9:0] dout,
    output logic [1:0] count
);

    logic [9:0] mem_q [2];
    logic [9:0] mem_d [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/udp_rx_drain_ctrl.sv
// Drains a good UDP datagram from the receive RAM: captures the 4-byte
// application header, then streams the payload over valid/ready.
import eth_rx_pkg::*;

module udp_rx_drain_ctrl (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_valid,
    input  logic [15:0]       rec_length,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [7:0]        ram_rd_data,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_sof,
    output logic              m_eof,
    output logic [15:0]       hdr_line,
    output logic [15:0]       hdr_flags,
    output logic              hdr_valid,
    output logic              busy,
    output logic              len_err,
    output logic [15:0]       drop_cnt
);

    drain_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       pay_q, pay_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_pay_q, rd_pay_d;
    logic [1:0]        rd_idx_q, rd_idx_d;
    logic              rd_sof_q, rd_sof_d;
    logic              rd_eof_q, rd_eof_d;
    logic [23:0]       hdr_b_q, hdr_b_d;
    logic [15:0]       line_q, line_d;
    logic [15:0]       flags_q, flags_d;
    logic              hdr_valid_q, hdr_valid_d;
    logic              len_err_q, len_err_d;
    logic [15:0]       drop_q, drop_d;

    logic       pop;
    logic       push;
    logic [9:0] head;
    logic [1:0] fifo_cnt;
    logic [2:0] occupancy;
    logic       credit_ok;
    logic       last_addr;
    logic       len_bad;
    logic       drop_inc;

    assign pop  = m_valid && m_ready;
    assign push = rd_vld_q && rd_pay_q;

    // Slots already committed: buffered bytes plus the byte on its way back.
    assign occupancy = {1'b0, fifo_cnt} + {2'b0, push} - {2'b0, pop};
    assign credit_ok = occupancy < 3'd2;
    assign last_addr = (16'(addr_q) == pay_q - 16'd1);
    assign len_bad   = (rec_length < 16'(UDP_HDR + HDR_BYTES))
                    || ((rec_length - 16'(UDP_HDR)) > 16'(MAX_PAY));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pay_d       = pay_q;
        rd_vld_d    = 1'b0;
        rd_pay_d    = 1'b0;
        rd_idx_d    = addr_q[1:0];
        rd_sof_d    = 1'b0;
        rd_eof_d    = 1'b0;
        hdr_b_d     = hdr_b_q;
        line_d      = line_q;
        flags_d     = flags_q;
        hdr_valid_d = 1'b0;
        len_err_d   = 1'b0;
        drop_inc    = 1'b0;
        drop_d      = drop_q;

        unique case (state_q)
            IDLE: begin
                addr_d = '0;
                if (rec_valid) begin
                    pay_d = rec_length - 16'(UDP_HDR);
                    if (len_bad) begin
                        len_err_d = 1'b1;
                        drop_inc  = 1'b1;
                    end else begin
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                rd_vld_d = 1'b1;
                addr_d   = addr_q + 1'b1;
                if (addr_q[1:0] == 2'd3) begin
                    state_d = (pay_q > 16'(HDR_BYTES)) ? PAY : DONE;
                end
            end
            PAY: begin
                if (credit_ok) begin
                    rd_vld_d = 1'b1;
                    rd_pay_d = 1'b1;
                    rd_sof_d = (16'(addr_q) == 16'(HDR_BYTES));
                    rd_eof_d = last_addr;
                    if (last_addr) begin
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (fifo_cnt == 2'd0 && !rd_vld_q) begin
                    state_d = IDLE;
                    addr_d  = '0;
                end
            end
        endcase

        if (rec_valid && state_q != IDLE) begin
            drop_inc = 1'b1;
        end
        if (drop_inc && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end

        // Both header fields are published together when byte 3 lands.
        if (rd_vld_q && !rd_pay_q) begin
            case (rd_idx_q)
                2'd0: hdr_b_d[23:16] = ram_rd_data;
                2'd1: hdr_b_d[15:8]  = ram_rd_data;
                2'd2: hdr_b_d[7:0]   = ram_rd_data;
                2'd3: begin
                    line_d      = hdr_b_q[23:8];
                    flags_d     = {hdr_b_q[7:0], ram_rd_data};
                    hdr_valid_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pay_q       <= '0;
            rd_vld_q    <= 1'b0;
            rd_pay_q    <= 1'b0;
            rd_idx_q    <= '0;
            rd_sof_q    <= 1'b0;
            rd_eof_q    <= 1'b0;
            hdr_b_q     <= '0;
            line_q      <= '0;
            flags_q     <= '0;
            hdr_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pay_q       <= pay_d;
            rd_vld_q    <= rd_vld_d;
            rd_pay_q    <= rd_pay_d;
            rd_idx_q    <= rd_idx_d;
            rd_sof_q    <= rd_sof_d;
            rd_eof_q    <= rd_eof_d;
            hdr_b_q     <= hdr_b_d;
            line_q      <= line_d;
            flags_q     <= flags_d;
            hdr_valid_q <= hdr_valid_d;
            len_err_q   <= len_err_d;
            drop_q      <= drop_d;
        end
    end

    udp_drain_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({rd_eof_q, rd_sof_q, ram_rd_data}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_cnt)
    );

    assign ram_rd_addr = addr_q;
    assign m_valid     = (fifo_cnt != 2'd0);
    assign m_data      = head[7:0];
    assign m_sof       = m_valid && head[8];
    assign m_eof       = m_valid && head[9];
    assign hdr_line    = line_q;
    assign hdr_flags   = flags_q;
    assign hdr_valid   = hdr_valid_q;
    assign busy        = (state_q != IDLE);
    assign len_err     = len_err_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_udp_rx_drain_ctrl.sv
// Scoreboard bench for udp_rx_drain_ctrl with a 1-cycle-latency RAM model.
// Stimulus pushes expected beats/headers/len_err; a negedge monitor pops them.
module tb_udp_rx_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rec_valid;
    logic [15:0] rec_length;
    logic [10:0] ram_rd_addr;
    logic [7:0]  ram_rd_data;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_sof;
    logic        m_eof;
    logic [15:0] hdr_line;
    logic [15:0] hdr_flags;
    logic        hdr_valid;
    logic        busy;
    logic        len_err;
    logic [15:0] drop_cnt;

    udp_rx_drain_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .rec_valid   (rec_valid),
        .rec_length  (rec_length),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_sof       (m_sof),
        .m_eof       (m_eof),
        .hdr_line    (hdr_line),
        .hdr_flags   (hdr_flags),
        .hdr_valid   (hdr_valid),
        .busy        (busy),
        .len_err     (len_err),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [2048];
    always @(posedge clk) ram_rd_data <= ram[ram_rd_addr];

    int n_chk = 0;
    int n_pass = 0;

    logic [9:0]  exp_beat [$];
    logic [31:0] exp_hdr  [$];
    logic [15:0] exp_lerr [$];

    bit         thru_chk = 1'b0;
    bit         lerr_quiet = 1'b0;
    int         lerr_seen = 0;
    int         cyc = 0;
    int         last_beat_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic [9:0] e_beat;
    logic [31:0] e_hdr;
    logic [15:0] e_lerr;
    int         exp_drop = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        n_chk++;
        $display("FAIL %s: got %0h, expected none", name, act);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {23'd0, m_valid, m_data}, {23'd0, 1'b1, prev_data});
            if (m_valid && m_ready) begin
                if (exp_beat.size() == 0) begin
                    fail("extra_beat", {22'd0, m_eof, m_sof, m_data});
                end else begin
                    e_beat = exp_beat.pop_front();
                    check("beat", {22'd0, m_eof, m_sof, m_data}, {22'd0, e_beat});
                    if (thru_chk && !e_beat[8])
                        check("beat_gap", cyc - last_beat_cyc, 1);
                    last_beat_cyc = cyc;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (hdr_valid) begin
                if (exp_hdr.size() == 0) begin
                    fail("extra_hdr", {hdr_line, hdr_flags});
                end else begin
                    e_hdr = exp_hdr.pop_front();
                    check("hdr", {hdr_line, hdr_flags}, e_hdr);
                end
            end
            if (len_err) begin
                if (lerr_quiet) begin
                    lerr_seen++;
                end else if (exp_lerr.size() == 0) begin
                    fail("extra_len_err", {16'd0, drop_cnt});
                end else begin
                    e_lerr = exp_lerr.pop_front();
                    check("len_err_drop", {16'd0, drop_cnt}, {16'd0, e_lerr});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] len);
        rec_length = len;
        rec_valid  = 1'b1;
        step();
        rec_valid  = 1'b0;
    endtask

    task automatic expect_pkt(input logic [15:0] len);
        int pay;
        pay = int'(len) - 8;
        exp_hdr.push_back({ram[0], ram[1], ram[2], ram[3]});
        for (int i = 4; i < pay; i++)
            exp_beat.push_back({i == pay - 1, i == 4, ram[i]});
    endtask

    task automatic wait_idle(input bit toggle, input int budget);
        int k;
        k = 0;
        while (k < budget) begin
            m_ready = toggle ? (k % 3 == 0) : 1'b1;
            step();
            if (!busy && !m_valid) break;
            k++;
        end
        m_ready = 1'b1;
        if (k >= budget) fail("drain_timeout", k);
        step();
        check("beats_left", exp_beat.size(), 0);
        check("hdrs_left", exp_hdr.size(), 0);
    endtask

    task automatic load_pkt16();
        logic [7:0] v [8];
        v = '{8'h00, 8'h05, 8'h80, 8'h01, 8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 0; i < 8; i++) ram[i] = v[i];
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
        rst = 1'b1;
        rec_valid = 1'b0;
        rec_length = 16'd0;
        m_ready = 1'b1;
        repeat (3) step();
        check("rst_stream", {20'd0, m_valid, m_sof, m_eof, m_data, busy}, 32'd0);
        check("rst_flags", {28'd0, hdr_valid, len_err, 2'd0}, 32'd0);
        check("rst_addr", {21'd0, ram_rd_addr}, 32'd0);
        check("rst_hdr", {hdr_line, hdr_flags}, 32'd0);
        check("rst_drop", {16'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
        step();

        // Test 1: 8-byte payload, full throughput, constants by hand
        load_pkt16();
        exp_hdr.push_back(32'h0005_8001);
        exp_beat.push_back({1'b0, 1'b1, 8'hA0});
        exp_beat.push_back({1'b0, 1'b0, 8'hA1});
        exp_beat.push_back({1'b0, 1'b0, 8'hA2});
        exp_beat.push_back({1'b1, 1'b0, 8'hA3});
        thru_chk = 1'b1;
        send(16'd16);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        wait_idle(1'b0, 100);
        thru_chk = 1'b0;

        // Test 2: same packet under 1,0,0 backpressure
        expect_pkt(16'd16);
        send(16'd16);
        wait_idle(1'b1, 200);

        // Test 3: header only
        ram[0] = 8'h12; ram[1] = 8'h34; ram[2] = 8'h56; ram[3] = 8'h78;
        exp_hdr.push_back(32'h1234_5678);
        send(16'd12);
        wait_idle(1'b0, 100);

        // Test 4: length rejects
        exp_lerr.push_back(16'd1);
        send(16'd10);
        step();
        check("rej_short_busy", {31'd0, busy}, 32'd0);
        check("rej_short_addr", {21'd0, ram_rd_addr}, 32'd0);
        exp_lerr.push_back(16'd2);
        send(16'd2064);
        step();
        check("rej_long_drop", {16'd0, drop_cnt}, 32'd2);
        check("rej_long_busy", {31'd0, busy}, 32'd0);
        check("lerr_left", exp_lerr.size(), 0);
        exp_drop = 2;

        // Test 5: 1000-byte drain with an ignored rec_valid
        ram[0] = 8'h02; ram[1] = 8'h1C; ram[2] = 8'h00; ram[3] = 8'h03;
        for (int i = 4; i < 1000; i++) ram[i] = 8'((i * 7 + 3) & 255);
        expect_pkt(16'd1008);
        send(16'd1008);
        step();
        step();
        send(16'd16);
        exp_drop++;
        check("ignore_drop", {16'd0, drop_cnt}, exp_drop);
        wait_idle(1'b0, 3000);

        // Test 6: reset mid-PAY, then drain and saturation
        expect_pkt(16'd1008);
        send(16'd1008);
        repeat (20) step();
        rst = 1'b1;
        exp_beat.delete();
        exp_hdr.delete();
        step();
        check("mid_rst_stream", {20'd0, m_valid, m_sof, m_eof, m_data, busy}, 32'd0);
        check("mid_rst_flags", {30'd0, hdr_valid, len_err}, 32'd0);
        check("mid_rst_addr", {21'd0, ram_rd_addr}, 32'd0);
        check("mid_rst_hdr", {hdr_line, hdr_flags}, 32'd0);
        check("mid_rst_drop", {16'd0, drop_cnt}, 32'd0);
        rst = 1'b0;
        step();
        load_pkt16();
        expect_pkt(16'd16);
        send(16'd16);
        wait_idle(1'b0, 100);

        lerr_quiet = 1'b1;
        rec_length = 16'd10;
        rec_valid = 1'b1;
        repeat (65535) step();
        rec_valid = 1'b0;
        step();
        lerr_quiet = 1'b0;
        check("preload_pulses", lerr_seen, 65535);
        check("preload_drop", {16'd0, drop_cnt}, 32'h0000_FFFF);
        exp_lerr.push_back(16'hFFFF);
        send(16'd10);
        step();
        check("sat_drop", {16'd0, drop_cnt}, 32'h0000_FFFF);
        check("sat_lerr_left", exp_lerr.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
